// File: rtl/riscv_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package riscv_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    localparam int HDR_LEN        = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects payload bytes into little-endian 32-bit words and keeps the running XOR checksum.
module word_assembler
    import riscv_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        last_byte,
    output logic        word_complete,
    output logic [31:0] word,
    output logic [7:0]  checksum
);

    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [23:0]           shift_q;

    assign last_byte = (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

    // NOTE: every register here uses <= so all updates see the pre-edge values of each other.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt      <= '0;
            shift_q       <= '0;
            word          <= '0;
            word_complete <= 1'b0;
            checksum      <= '0;
        end else begin
            word_complete <= 1'b0;
            if (clear) begin
                byte_cnt <= '0;
                shift_q  <= '0;
                checksum <= '0;
            end else if (byte_en) begin
                byte_cnt <= byte_cnt + 1'b1;
                checksum <= checksum ^ byte_data;
                // Earlier bytes sit lower, so byte k ends up in bits [8k+7:8k].
                if (last_byte) begin
                    word          <= {byte_data, shift_q};
                    word_complete <= 1'b1;
                end else begin
                    shift_q <= {byte_data, shift_q[23:8]};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a counted, checksummed byte stream into IMEM and holds the core in reset until done.
module imem_loader
    import riscv_loader_pkg::*;
#(
    parameter int IMEM_SIZE = 16,
    parameter int AW        = $clog2(IMEM_SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    input  logic          rearm,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          core_reset,
    output logic          load_done,
    output logic          load_error
);

    loader_state_t state;
    logic [7:0]    n_lo;
    logic [15:0]   n_words;
    logic [15:0]   words_seen;
    logic          last_byte;
    logic          word_complete;
    logic [7:0]    checksum;
    logic [15:0]   n_next;
    logic          xfer;
    logic          clear;

    assign xfer   = byte_valid && byte_ready;
    assign n_next = {byte_data, n_lo};
    assign clear  = rearm && (state == ST_DONE || state == ST_ERR);

    word_assembler u_asm (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .byte_en       (xfer && state == ST_DATA),
        .byte_data     (byte_data),
        .last_byte     (last_byte),
        .word_complete (word_complete),
        .word          (imem_wdata),
        .checksum      (checksum)
    );

    assign imem_we = word_complete;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_HDR0;
            n_lo       <= '0;
            n_words    <= '0;
            words_seen <= '0;
            imem_addr  <= '0;
            byte_ready <= 1'b1;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            // The index advances at the end of each write pulse, wrapping at 2^AW.
            if (word_complete)
                imem_addr <= imem_addr + AW'(1);

            case (state)
                ST_HDR0: begin
                    if (xfer) begin
                        n_lo  <= byte_data;
                        state <= ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (xfer) begin
                        n_words <= n_next;
                        if (n_next == 16'd0 || int'(n_next) > IMEM_SIZE) begin
                            state      <= ST_ERR;
                            byte_ready <= 1'b0;
                            load_error <= 1'b1;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer && last_byte) begin
                        words_seen <= words_seen + 16'd1;
                        if (words_seen == n_words - 16'd1)
                            state <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (xfer) begin
                        byte_ready <= 1'b0;
                        if (byte_data == checksum) begin
                            state      <= ST_DONE;
                            core_reset <= 1'b0;
                            load_done  <= 1'b1;
                        end else begin
                            state      <= ST_ERR;
                            load_error <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (rearm) begin
                        state      <= ST_HDR0;
                        words_seen <= '0;
                        imem_addr  <= '0;
                        byte_ready <= 1'b1;
                        core_reset <= 1'b1;
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
                    end
                end
                default: state <= ST_HDR0;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of whole streams plus reset, stall, rearm and DONE corner cases.
module tb_imem_loader;

    localparam int IMEM_SIZE = 16;
    localparam int AW        = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          rearm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_reset;
    logic          load_done;
    logic          load_error;

    imem_loader #(.IMEM_SIZE(IMEM_SIZE), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .rearm      (rearm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    // Write log captured from the IMEM port.
    int          wr_cnt = 0;
    logic [31:0] wr_data [64];
    logic [AW-1:0] wr_addr [64];

    always @(posedge clk) begin
        if (imem_we && wr_cnt < 64) begin
            wr_addr[wr_cnt] = imem_addr;
            wr_data[wr_cnt] = imem_wdata;
            wr_cnt = wr_cnt + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_rearm();
        rearm = 1'b1;
        @(negedge clk);
        rearm = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [95:0] bytes;   // stream bytes, first byte in the top octet
        int          len;
        logic        done;
        logic        err;
        int          nwr;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int          base;
        logic [31:0] words [16];
        logic [7:0]  chk;
        logic [7:0]  b;

        // The payload XOR of 13 00 00 00 93 00 50 00 is 0xD0; EF BE AD DE gives 0x22.
        vecs[0] = '{"two_word_ok",  96'h02_00_13_00_00_00_93_00_50_00_D0_00, 11, 1'b1, 1'b0, 2, 32'h00000013, 32'h00500093};
        vecs[1] = '{"two_word_bad", 96'h02_00_13_00_00_00_93_00_50_00_C1_00, 11, 1'b0, 1'b1, 2, 32'h00000013, 32'h00500093};
        vecs[2] = '{"n_17",         96'h11_00_00_00_00_00_00_00_00_00_00_00, 2,  1'b0, 1'b1, 0, 32'h0, 32'h0};
        vecs[3] = '{"n_0",          96'h00_00_00_00_00_00_00_00_00_00_00_00, 2,  1'b0, 1'b1, 0, 32'h0, 32'h0};
        vecs[4] = '{"n_256",        96'h00_01_00_00_00_00_00_00_00_00_00_00, 2,  1'b0, 1'b1, 0, 32'h0, 32'h0};
        vecs[5] = '{"one_word_ok",  96'h01_00_EF_BE_AD_DE_22_00_00_00_00_00, 7,  1'b1, 1'b0, 1, 32'hDEADBEEF, 32'h0};
        vecs[6] = '{"one_word_bad", 96'h01_00_EF_BE_AD_DE_23_00_00_00_00_00, 7,  1'b0, 1'b1, 1, 32'hDEADBEEF, 32'h0};

        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        rearm      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_core_reset", core_reset, 1);
        check("rst_done",       load_done,  0);
        check("rst_error",      load_error, 0);
        check("rst_we",         imem_we,    0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", byte_ready, 1);

        for (int v = 0; v < 7; v++) begin
            base = wr_cnt;
            for (int i = 0; i < vecs[v].len; i++) begin
                b = vecs[v].bytes[95 - 8*i -: 8];
                send_byte(b, 0);
            end
            check({vecs[v].name, "_done"},       load_done,    vecs[v].done);
            check({vecs[v].name, "_error"},      load_error,   vecs[v].err);
            check({vecs[v].name, "_core_reset"}, core_reset,   !vecs[v].done);
            check({vecs[v].name, "_ready"},      byte_ready,   0);
            check({vecs[v].name, "_nwr"},        wr_cnt - base, vecs[v].nwr);
            if (vecs[v].nwr > 0) begin
                check({vecs[v].name, "_a0"}, wr_addr[base], 0);
                check({vecs[v].name, "_w0"}, wr_data[base], vecs[v].w0);
            end
            if (vecs[v].nwr > 1) begin
                check({vecs[v].name, "_a1"}, wr_addr[base+1], 1);
                check({vecs[v].name, "_w1"}, wr_data[base+1], vecs[v].w1);
            end
            pulse_rearm();
            check({vecs[v].name, "_rearm_ready"}, byte_ready, 1);
            check({vecs[v].name, "_rearm_flags"}, {load_done, load_error, core_reset}, 3'b001);
            check({vecs[v].name, "_rearm_addr"},  imem_addr, 0);
        end

        // Asynchronous reset in the middle of a word; the partial word must never be written.
        base = wr_cnt;
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #1 reset = 1'b1;
        #1;
        check("async_we",    imem_we,    0);
        check("async_addr",  imem_addr,  0);
        check("async_wdata", imem_wdata, 0);
        check("async_flags", {core_reset, load_done, load_error}, 3'b100);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        foreach (vecs[0].bytes[i]) if (i < 0) b = 0;
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h44, 0);
        check("after_rst_nwr",  wr_cnt - base, 1);
        check("after_rst_addr", wr_addr[base], 0);
        check("after_rst_data", wr_data[base], 32'h44332211);
        check("after_rst_done", load_done, 1);

        // Bytes offered in DONE are refused and change nothing.
        base       = wr_cnt;
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (4) @(negedge clk);
        check("done_ready", byte_ready, 0);
        check("done_hold",  {load_done, load_error, core_reset}, 3'b100);
        byte_valid = 1'b0;
        check("done_nwr",   wr_cnt - base, 0);

        // Full-depth load with random stalls and an ignored rearm mid-stream.
        pulse_rearm();
        base = wr_cnt;
        chk  = 8'h00;
        send_byte(8'h10, $urandom_range(0, 2));
        send_byte(8'h00, $urandom_range(0, 2));
        for (int w = 0; w < 16; w++) begin
            words[w] = $urandom;
            for (int k = 0; k < 4; k++) begin
                b   = words[w][8*k +: 8];
                chk = chk ^ b;
                send_byte(b, $urandom_range(0, 2));
                if (w == 0 && k == 1) pulse_rearm();
            end
        end
        send_byte(chk, $urandom_range(0, 2));
        check("full_nwr",  wr_cnt - base, 16);
        for (int w = 0; w < 16; w++) begin
            check($sformatf("full_a%0d", w), wr_addr[base+w], w);
            check($sformatf("full_w%0d", w), wr_data[base+w], words[w]);
        end
        check("full_done",  {load_done, load_error, core_reset}, 3'b100);
        check("full_wrap",  imem_addr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
